// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, registers ir1/pc1/valid1, and freezes after issuing a trap.
// Optional backward-branch predictor is enabled with `define BRANCH_PREDICT_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  TRAP_OP  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ir1,
  output logic [15:0] pc1,
  output logic        valid1,
  output logic        pred_taken1,
  output logic        fetch_halted
);

  typedef enum logic {RUN, TRAPPED} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] ir1_q;
  logic [15:0] pc1_q;
  logic        valid1_q;
  logic        halted_q;
  logic        is_trap;
  logic        fetch_en;

  assign is_trap  = (imem_data[15:8] == TRAP_OP);
  // A new word is accepted only in RUN with no squash and no interlock.
  assign fetch_en = (state_q == RUN) && !redirect && !stall;

`ifdef BRANCH_PREDICT_EN
  logic pred_hit;
  logic pred_q;

  // Backward bz/bnz are predicted taken; the 8-bit offset is sign-extended.
  assign pred_hit = (imem_data[15:13] == 3'b111) && imem_data[11];
  assign pc_d     = pred_hit ? (pc_q + {{8{imem_data[11]}}, imem_data[11:4]})
                             : (pc_q + 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_q <= 1'b0;
    end else if (fetch_en) begin
      pred_q <= pred_hit;
    end
  end

  assign pred_taken1 = pred_q;
`else
  assign pc_d        = pc_q + 16'd1;
  assign pred_taken1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ir1_q    <= 16'h0000;
      pc1_q    <= 16'h0000;
      valid1_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            pc_q     <= redirect_pc;
            valid1_q <= 1'b0;
          end else if (!stall) begin
            ir1_q    <= imem_data;
            pc1_q    <= pc_q;
            valid1_q <= 1'b1;
            pc_q     <= pc_d;
            if (is_trap) begin
              state_q  <= TRAPPED;
              halted_q <= 1'b1;
            end
          end
        end
        TRAPPED: begin
          // An older branch resolving late can still squash the trap.
          if (redirect) begin
            pc_q     <= redirect_pc;
            valid1_q <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= RUN;
          end else if (!stall) begin
            valid1_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign ir1          = ir1_q;
  assign pc1          = pc1_q;
  assign valid1       = valid1_q;
  assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed sequences, scoreboard of issued instructions plus cycle-level checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ir1;
  logic [15:0] pc1;
  logic        valid1;
  logic        pred_taken1;
  logic        fetch_halted;

  logic [15:0] mem [0:65535];

`ifdef BRANCH_PREDICT_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic        pred;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir1(ir1), .pc1(pc1), .valid1(valid1), .pred_taken1(pred_taken1),
    .fetch_halted(fetch_halted)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 65536; i++) mem[i] = {4'h1, i[11:0]};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ir, input logic [15:0] pc, input logic pred);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    e.pred = pred;
    sbq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
  endtask

  // Monitor: a newly presented instruction is valid1 not merely held over by a stall.
  logic l_stall = 1'b0, l_redir = 1'b0, l_reset = 1'b1;
  always @(posedge clk) begin
    l_stall <= stall;
    l_redir <= redirect;
    l_reset <= reset;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!l_reset && valid1 && !(l_stall && !l_redir)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ir1=%h pc1=%h expected no instruction", ir1, pc1);
      end else begin
        e = sbq.pop_front();
        chk("sb_ir1", {16'h0, ir1}, {16'h0, e.ir});
        chk("sb_pc1", {16'h0, pc1}, {16'h0, e.pc});
        chk("sb_pred", {31'h0, pred_taken1}, {31'h0, e.pred});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // 1: reset state, three fetches, trap freezes fetch
    fill();
    mem[0] = 16'h7012; mem[1] = 16'h7023; mem[2] = 16'h0000;
    do_reset(2);
    chk("rst_ir1", {16'h0, ir1}, 32'h0);
    chk("rst_pc1", {16'h0, pc1}, 32'h0);
    chk("rst_valid1", {31'h0, valid1}, 32'h0);
    chk("rst_pred", {31'h0, pred_taken1}, 32'h0);
    chk("rst_halted", {31'h0, fetch_halted}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr}, 32'h0);
    push(16'h7012, 16'h0, 1'b0);
    push(16'h7023, 16'h1, 1'b0);
    push(16'h0000, 16'h2, 1'b0);
    cyc(); cyc(); cyc();
    chk("t1_halted", {31'h0, fetch_halted}, 32'h1);
    chk("t1_addr", {16'h0, imem_addr}, 32'h3);
    cyc(); cyc();
    chk("t1_halted_hold", {31'h0, fetch_halted}, 32'h1);
    chk("t1_addr_hold", {16'h0, imem_addr}, 32'h3);
    chk("t1_bubble", {31'h0, valid1}, 32'h0);

    // 2: stall holds stage-1 for three cycles without loss or duplication
    fill();
    do_reset(1);
    chk("t2_rst_halted", {31'h0, fetch_halted}, 32'h0);
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), 16'(i), 1'b0);
    cyc(); cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_stall_pc1", {16'h0, pc1}, 32'h1);
      chk("t2_stall_ir1", {16'h0, ir1}, 32'h1001);
      chk("t2_stall_addr", {16'h0, imem_addr}, 32'h2);
    end
    stall = 1'b0;
    cyc();
    chk("t2_rel_pc1a", {16'h0, pc1}, 32'h2);
    cyc();
    chk("t2_rel_pc1b", {16'h0, pc1}, 32'h3);

    // 3: redirect beats stall
    do_reset(1);
    push(16'h1000, 16'h0, 1'b0);
    cyc();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    push(16'h1040, 16'h0040, 1'b0);
    cyc();
    chk("t3_squash", {31'h0, valid1}, 32'h0);
    chk("t3_addr", {16'h0, imem_addr}, 32'h40);
    stall = 1'b0; redirect = 1'b0;
    cyc();
    chk("t3_valid", {31'h0, valid1}, 32'h1);
    chk("t3_pc1", {16'h0, pc1}, 32'h40);

    // 4: trap squashed by a late redirect
    fill();
    mem[5] = 16'h0000;
    do_reset(1);
    for (int i = 0; i < 5; i++) push(16'h1000 + 16'(i), 16'(i), 1'b0);
    push(16'h0000, 16'h5, 1'b0);
    repeat (6) cyc();
    chk("t4_halted", {31'h0, fetch_halted}, 32'h1);
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0010;
    cyc();
    chk("t4_unhalt", {31'h0, fetch_halted}, 32'h0);
    chk("t4_addr", {16'h0, imem_addr}, 32'h10);
    chk("t4_squash", {31'h0, valid1}, 32'h0);
    redirect = 1'b0;
    push(16'h1010, 16'h0010, 1'b0);
    cyc();
    chk("t4_pc1", {16'h0, pc1}, 32'h10);
    chk("t4_running", {31'h0, fetch_halted}, 32'h0);

    // 5: PC wraps, then reset mid-run
    do_reset(1);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    chk("t5_addr_ffff", {16'h0, imem_addr}, 32'hFFFF);
    redirect = 1'b0;
    push(16'h1FFF, 16'hFFFF, 1'b0);
    cyc();
    chk("t5_pc1", {16'h0, pc1}, 32'hFFFF);
    chk("t5_wrap", {16'h0, imem_addr}, 32'h0);
    push(16'h1000, 16'h0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_ir1", {16'h0, ir1}, 32'h0);
    chk("t5_rst_pc1", {16'h0, pc1}, 32'h0);
    chk("t5_rst_valid", {31'h0, valid1}, 32'h0);
    chk("t5_rst_halted", {31'h0, fetch_halted}, 32'h0);
    chk("t5_rst_addr", {16'h0, imem_addr}, 32'h0);

    // 6: backward branch prediction (or plain increment without predictor)
    mem[8] = 16'heff0;
    redirect = 1'b1; redirect_pc = 16'h0008;
    cyc();
    redirect = 1'b0;
    push(16'heff0, 16'h0008, PE);
    cyc();
    chk("t6_addr", {16'h0, imem_addr}, PE ? 32'h7 : 32'h9);
    chk("t6_pred", {31'h0, pred_taken1}, {31'h0, PE});
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    @(negedge clk);
    chk("sb_drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
